counter_arbiter: RTL

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : counter_arbiter
//  Purpose  : Round-robin arbiter that lends one shared up-counter to a single
//             requester at a time. The winner's terminal count is latched at
//             grant time; the counter runs 0..term, then a one-cycle done
//             pulse is returned to the owner. Abort ends a window early with
//             no done pulse.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous active-high reset
//             req    - per-requester level request [NREQ]
//             len    - packed terminal counts, slice i = requester i [NREQ*CW]
//             abort  - terminate the current window (RUN only)
//             grant  - one-hot owner of the counter, zero when unowned
//             count  - current counter value
//             busy   - high while a window is in RUN or DONE
//             done   - one-cycle completion pulse to the owner
//  Revision : 1.0 - initial release
// ============================================================================
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic               abort,
    output logic [NREQ-1:0]    grant,
    output logic [CW-1:0]      count,
    output logic               busy,
    output logic [NREQ-1:0]    done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_owner;
    logic [CW-1:0]     r_term;
    logic [CW-1:0]     r_count;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic              r_busy;

    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_idx;
    logic [CW-1:0]     w_term;
    logic [NREQ-1:0]   w_win_onehot;

    // Round-robin search. Candidates are visited from farthest to nearest
    // relative to ptr, so the nearest requester after ptr is the last one
    // written and therefore wins; this avoids a priority "found" chain.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_term       = CW'(len >> (int'(w_win) * CW));
    assign w_win_onehot = NREQ'(1) << w_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_owner <= '0;
            r_term  <= '0;
            r_count <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_found) begin
                        r_grant <= w_win_onehot;
                        r_owner <= w_win;
                        r_term  <= w_term;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Abort wins over reaching the terminal count.
                    if (abort) begin
                        r_ptr   <= r_owner;
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_count == r_term) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_ptr   <= r_owner;
                    r_grant <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire
